// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared constants and state encoding for the PS/2 host command sequencer.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  localparam int unsigned TIMER_W = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT
  } state_e;

  // Bytes swallowed while a command is outstanding.
  function automatic logic is_response(input logic [7:0] b);
    return (b == RSP_ACK) || (b == RSP_RESEND) || (b == RSP_BAT_OK);
  endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Request, transmitter, receiver and status signals of the command sequencer.
interface ps2_cmd_sequencer_if;
  logic       rst_req;
  logic       led_valid;
  logic       led_ready;
  logic [2:0] led_bits;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_err;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       code_valid;
  logic [7:0] code_data;
  logic       busy;
  logic       error;
  logic       kb_ok;

  modport master (
    input  rst_req, led_valid, led_bits, tx_busy, tx_err, rx_valid, rx_data,
    output led_ready, tx_start, tx_data, code_valid, code_data, busy, error, kb_ok
  );

  modport slave (
    output rst_req, led_valid, led_bits, tx_busy, tx_err, rx_valid, rx_data,
    input  led_ready, tx_start, tx_data, code_valid, code_data, busy, error, kb_ok
  );
endinterface

// File: rtl/ps2_cmd_sequencer_timer.sv
// Loadable down-counter that saturates at zero; expired while the count is zero.
module ps2_timeout_timer
  import ps2_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)            cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 keyboard command controller: sends reset / set-LED commands, handles
// ACK/RESEND/BAT with retries and timeouts, forwards other bytes as scan codes.
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC     = 1_000_000,
  parameter int unsigned BAT_TIMEOUT_CYC = 40_000_000,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  ps2_cmd_sequencer_if.master bus
);

  localparam int unsigned        RETRY_W   = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [7:0]           cur_q, cur_d;
  logic [7:0]           arg_q, arg_d;
  logic                 has_arg_q, has_arg_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 rst_pend_q, rst_pend_d;
  logic                 error_q, error_d;
  logic                 kb_ok_q, kb_ok_d;
  logic                 code_valid_q, code_valid_d;
  logic [7:0]           code_data_q, code_data_d;
  logic                 tx_busy_q;
  logic                 tx_start;
  logic                 fwd;
  logic                 do_retry;
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_val;
  logic                 tmr_expired;

  ps2_timeout_timer #(.W(TIMER_W)) u_timer (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      retry_q      <= '0;
      rst_pend_q   <= 1'b0;
      error_q      <= 1'b0;
      kb_ok_q      <= 1'b0;
      code_valid_q <= 1'b0;
      code_data_q  <= '0;
      tx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      arg_q        <= arg_d;
      has_arg_q    <= has_arg_d;
      retry_q      <= retry_d;
      rst_pend_q   <= rst_pend_d;
      error_q      <= error_d;
      kb_ok_q      <= kb_ok_d;
      code_valid_q <= code_valid_d;
      code_data_q  <= code_data_d;
      tx_busy_q    <= bus.tx_busy;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    retry_d    = retry_q;
    rst_pend_d = rst_pend_q | bus.rst_req;
    error_d    = error_q;
    kb_ok_d    = kb_ok_q;
    tx_start   = 1'b0;
    fwd        = 1'b0;
    do_retry   = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = TIMER_W'(TIMEOUT_CYC);

    unique case (state_q)
      ST_IDLE: begin
        fwd = bus.rx_valid;
        if (rst_pend_d) begin
          cur_d      = CMD_RESET;
          has_arg_d  = 1'b0;
          retry_d    = '0;
          error_d    = 1'b0;
          kb_ok_d    = 1'b0;
          rst_pend_d = 1'b0;
          state_d    = ST_SEND;
        end else if (bus.led_valid) begin
          cur_d     = CMD_SET_LED;
          arg_d     = {5'b0, bus.led_bits};
          has_arg_d = 1'b1;
          retry_d   = '0;
          error_d   = 1'b0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        fwd = bus.rx_valid && !is_response(bus.rx_data);
        if (!bus.tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        fwd = bus.rx_valid && !is_response(bus.rx_data);
        if (bus.tx_err) begin
          do_retry = 1'b1;
        end else if (tx_busy_q && !bus.tx_busy) begin
          tmr_load = 1'b1;
          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A received byte takes precedence over a coincident timer expiry.
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_ACK) begin
            if (has_arg_q) begin
              cur_d     = arg_q;
              has_arg_d = 1'b0;
              retry_d   = '0;
              state_d   = ST_SEND;
            end else if (cur_q == CMD_RESET) begin
              tmr_load = 1'b1;
              tmr_val  = TIMER_W'(BAT_TIMEOUT_CYC);
              state_d  = ST_WAIT_BAT;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (bus.rx_data == RSP_RESEND) begin
            do_retry = 1'b1;
          end else begin
            fwd = !is_response(bus.rx_data);
          end
        end else if (tmr_expired) begin
          do_retry = 1'b1;
        end
      end
      ST_WAIT_BAT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_BAT_OK) begin
            kb_ok_d = 1'b1;
            state_d = ST_IDLE;
          end else if (bus.rx_data == RSP_BAT_FAIL) begin
            error_d = 1'b1;
            kb_ok_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            fwd = !is_response(bus.rx_data);
          end
        end else if (tmr_expired) begin
          error_d = 1'b1;
          kb_ok_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_retry) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = ST_SEND;
      end else begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
    end

    code_valid_d = fwd;
    code_data_d  = fwd ? bus.rx_data : code_data_q;
  end

  assign bus.led_ready  = (state_q == ST_IDLE) && !rst_pend_q && !bus.rst_req;
  assign bus.tx_start   = tx_start;
  assign bus.tx_data    = cur_q;
  assign bus.code_valid = code_valid_q;
  assign bus.code_data  = code_data_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.error      = error_q;
  assign bus.kb_ok      = kb_ok_q;

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Host-side command controller for the PS/2 keyboard port. It issues keyboard commands (reset 0xFF; set-LEDs 0xED followed by an argument byte) to a byte-level PS/2 transmitter. It watches the received-byte stream for ACK, RESEND and BAT responses, retries on failure, and times out. Received bytes that are not responses are forwarded as scan codes, so downstream decode logic sees a clean scan-code stream.

Parameters:
TIMEOUT_CYC, 1_000_000, cycles to wait for ACK (20 ms at 50 MHz)
BAT_TIMEOUT_CYC, 40_000_000, cycles to wait for BAT result after reset ACK (800 ms)
MAX_RETRY, 3, resends allowed per byte before declaring error

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RESET_N  in  1  asynchronous active-low reset
rst_req  in  1  pulse: request keyboard reset; latched until serviced
led_valid  in  1  LED update request valid
led_ready  out  1  high in IDLE with no pending rst_req; transfer on valid&&ready
led_bits  in  3  {caps, num, scroll}; sampled at transfer
tx_start  out  1  one-cycle pulse: transmit tx_data
tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls
tx_busy  in  1  transmitter busy; rises the cycle after tx_start
tx_err  in  1  one-cycle pulse: transmit failed (no device ACK bit)
rx_valid  in  1  one-cycle strobe per received byte
rx_data  in  8  received byte
code_valid  out  1  one-cycle strobe: forwarded scan code
code_data  out  8  forwarded byte; held until next code_valid
busy  out  1  high in any state other than IDLE
error  out  1  sticky; cleared on acceptance of the next request
kb_ok  out  1  set on BAT 0xAA; cleared on rst_req acceptance or BAT failure

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE. All outputs 0 except led_ready=1. Retry counter, timer and pending-reset latch cleared. A reset asserted mid-command abandons the command with no further tx_start.
- States: IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT.
- IDLE:
  - A pending reset has priority over led_valid in the same cycle. It loads cur=0xFF, has_arg=0, clears error and kb_ok, then goes to SEND.
  - Otherwise, led_valid&&led_ready loads cur=0xED and arg={5'b0,led_bits}, sets has_arg=1, clears error, then goes to SEND.
- SEND: when tx_busy=0, pulse tx_start with tx_data=cur, then go to WAIT_TX. First tx_start comes exactly 1 cycle after acceptance if tx_busy is low.
- WAIT_TX:
  - tx_err: counts as a resend, handled by the retry rule.
  - tx_busy falling: load timer=TIMEOUT_CYC, go to WAIT_ACK.
- WAIT_ACK:
  - rx 0xFA:
    - If has_arg, set cur=arg, has_arg=0, retry=0, go to SEND.
    - Else if cur was 0xFF, load timer=BAT_TIMEOUT_CYC and go to WAIT_BAT.
    - Else go to IDLE.
  - rx 0xFE, or timer reaching 0: retry rule.
  - Any other rx byte: forwarded on code_valid/code_data; state unchanged.
- Retry rule: if retry<MAX_RETRY, increment retry and go to SEND with the same cur. Otherwise set error=1 and go to IDLE.
- WAIT_BAT:
  - rx 0xAA: kb_ok=1, go to IDLE.
  - rx 0xFC, or timeout: error=1, go to IDLE.
  - Other bytes are forwarded.
- IDLE forwards every rx byte. 0xFA, 0xFE and 0xAA are never forwarded while a command is outstanding; in IDLE they are forwarded.
- Simultaneous rx_valid and timer expiry in the same cycle: rx_valid wins.
- rst_req arriving while busy: latched. The current command completes (or errors) first, then the reset runs.
- Timer: 26-bit down-counter, loaded on entry to WAIT_ACK/WAIT_BAT. Expiry is when it reaches 0; no wrap.
- retry counter width: clog2(MAX_RETRY+1).

Decomposition:
- Shared package ps2_pkg:
  - Command constants: CMD_RESET=8'hFF, CMD_SET_LED=8'hED.
  - Response constants: RSP_ACK=8'hFA, RSP_RESEND=8'hFE, RSP_BAT_OK=8'hAA, RSP_BAT_FAIL=8'hFC.
  - State encoding.
- One sub-module: ps2_timeout_timer (load value, load strobe, expired flag; CLOCK_50/RESET_N).

Test Plan:
- led_valid with led_bits=3'b101; transmitter model idle; keyboard answers FA to each byte -> tx_data 0xED then 0x05; busy returns low 1 cycle after the second FA; error=0; no code_valid.
- rst_req; keyboard answers FA then AA -> tx_data 0xFF once; kb_ok=1; busy low; neither FA nor AA forwarded.
- led_valid; keyboard answers FE twice then FA to 0xED, then FA to the argument -> 0xED sent 3 times, argument sent once; error=0.
- No keyboard response -> 0xED sent 1+MAX_RETRY=4 times, spaced ≥TIMEOUT_CYC apart; then error=1 and busy=0; the next accepted request clears error.
- rx 0x1C during WAIT_ACK, then FA -> code_valid once with code_data 0x1C; command completes normally.
- Assert RESET_N low during WAIT_ACK, release, then rx 0xFA -> outputs at reset values immediately; after release, 0xFA is forwarded as a code; no tx_start.
